// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: ISA width, reset/bubble constants and fetch FSM states.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSN_DEFAULT = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    // Instruction fetch addresses must be word aligned.
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority is reset > flush > load; otherwise it holds.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSN = NOP_INSN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_insn,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_insn,
    output logic            o_valid
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_insn;
    logic            r_valid;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_pc    <= '0;
            r_insn  <= NOP_INSN;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_insn  <= i_insn;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_insn  = r_insn;
    assign o_valid = r_valid;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: program counter, redirect/stall handling, misaligned-target trap.
module pc_fetch
    import riscv_pkg::*;
#(
    parameter int              ADDR_W   = 10,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSN = NOP_INSN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_target,
    input  logic [XLEN-1:0]   insn_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   if_id_pc,
    output logic [XLEN-1:0]   if_id_insn,
    output logic              if_id_valid,
    output logic              halted,
    output logic              misalign
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic            r_misalign;
    logic            w_set_misalign;
    logic            w_load;
    logic            w_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_misalign <= r_misalign | w_set_misalign;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_set_misalign = 1'b0;
        w_load         = 1'b0;
        w_flush        = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (redirect) begin
                    // A redirect overrides a stall: the stalled instruction is on the wrong path.
                    w_flush = 1'b1;
                    if (is_word_aligned(redirect_target)) begin
                        w_pc_next = redirect_target;
                    end else begin
                        w_state_next   = ST_HALT;
                        w_set_misalign = 1'b1;
                    end
                end else if (!stall) begin
                    w_pc_next = r_pc + XLEN'(4);
                    w_load    = 1'b1;
                end
            end
            ST_HALT: begin
                w_flush = 1'b1;
            end
        endcase
    end

    if_id_reg #(
        .NOP_INSN (NOP_INSN)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_pc    (r_pc),
        .i_insn  (insn_in),
        .o_pc    (if_id_pc),
        .o_insn  (if_id_insn),
        .o_valid (if_id_valid)
    );

    // Only the word index reaches memory, so fetch wraps at every 4 KB boundary.
    assign pc_out   = r_pc[ADDR_W+1:2];
    assign pc       = r_pc;
    assign halted   = (r_state == ST_HALT);
    assign misalign = r_misalign;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: per-scenario tasks with a queue of expected post-edge outputs.
module tb_pc_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] insn_in;
    logic [9:0]  pc_out;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_insn;
    logic        if_id_valid;
    logic        halted;
    logic        misalign;

    logic [31:0] mem [1024];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [9:0]  idx;
        logic [31:0] ipc;
        logic [31:0] insn;
        logic        valid;
        logic        halted;
        logic        mis;
    } obs_t;

    obs_t exp_q[$];
    obs_t got;
    obs_t want;

    pc_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .insn_in         (insn_in),
        .pc_out          (pc_out),
        .pc              (pc),
        .if_id_pc        (if_id_pc),
        .if_id_insn      (if_id_insn),
        .if_id_valid     (if_id_valid),
        .halted          (halted),
        .misalign        (misalign)
    );

    always #5 clk = ~clk;

    assign insn_in = mem[pc_out];

    function automatic obs_t snap();
        return '{pc, pc_out, if_id_pc, if_id_insn, if_id_valid, halted, misalign};
    endfunction

    function automatic obs_t mk(input logic [31:0] p, input logic [31:0] ipc, input logic [31:0] ins,
                                input logic v, input logic h, input logic m);
        obs_t o;
        o.pc = p; o.idx = p[11:2]; o.ipc = ipc; o.insn = ins;
        o.valid = v; o.halted = h; o.mis = m;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("pc=%h idx=%0d ifpc=%h insn=%h v=%b h=%b m=%b",
                         o.pc, o.idx, o.ipc, o.insn, o.valid, o.halted, o.mis);
    endfunction

    task automatic drive_edge(input logic r, input logic s, input logic rd, input logic [31:0] t);
        @(negedge clk);
        rst = r; stall = s; redirect = rd; redirect_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_q.push_back(mk(32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0));
        drive_edge(1'b1, 1'b1, 1'b0, 32'h0);
        got = snap(); want = exp_q.pop_front(); n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset: got %s want %s", fmt(got), fmt(want));
        end
    endtask

    task automatic test_sequential();
        test_reset();
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(mk(32'(4 * k), 32'(4 * (k - 1)), 32'(k), 1'b1, 1'b0, 1'b0));
            drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
            got = snap(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL sequential[%0d]: got %s want %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_stall();
        test_reset();
        for (int k = 0; k < 6; k++) begin
            // two advances to pc=8, three stalled cycles, then release
            if (k < 2)      exp_q.push_back(mk(32'(4 * (k + 1)), 32'(4 * k), 32'(k + 1), 1'b1, 1'b0, 1'b0));
            else if (k < 5) exp_q.push_back(mk(32'd8, 32'd4, 32'd2, 1'b1, 1'b0, 1'b0));
            else            exp_q.push_back(mk(32'd12, 32'd8, 32'd3, 1'b1, 1'b0, 1'b0));
            drive_edge(1'b0, (k >= 2 && k < 5), 1'b0, 32'h0);
            got = snap(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL stall[%0d]: got %s want %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_redirect_stall();
        test_reset();
        for (int k = 1; k <= 12; k++) begin
            exp_q.push_back(mk(32'(4 * k), 32'(4 * (k - 1)), 32'(k), 1'b1, 1'b0, 1'b0));
            drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
            got = snap(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL run_to_48[%0d]: got %s want %s", k, fmt(got), fmt(want));
            end
        end
        exp_q.push_back(mk(32'h60, 32'h0, NOP, 1'b0, 1'b0, 1'b0));
        drive_edge(1'b0, 1'b1, 1'b1, 32'h60);
        got = snap(); want = exp_q.pop_front(); n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL redirect_stall: got %s want %s", fmt(got), fmt(want));
        end
        exp_q.push_back(mk(32'h64, 32'h60, 32'd25, 1'b1, 1'b0, 1'b0));
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        got = snap(); want = exp_q.pop_front(); n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL redirect_target_fetch: got %s want %s", fmt(got), fmt(want));
        end
    endtask

    task automatic test_misalign();
        // entered with pc=0x64 from the previous scenario
        exp_q.push_back(mk(32'h64, 32'h0, NOP, 1'b0, 1'b1, 1'b1));
        drive_edge(1'b0, 1'b0, 1'b1, 32'h62);
        got = snap(); want = exp_q.pop_front(); n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL misalign_trap: got %s want %s", fmt(got), fmt(want));
        end
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(mk(32'h64, 32'h0, NOP, 1'b0, 1'b1, 1'b1));
            drive_edge(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       {20'h0, 10'($urandom_range(0, 1023)), 2'b00});
            got = snap(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: got %s want %s", k, fmt(got), fmt(want));
            end
        end
        test_reset();
        exp_q.push_back(mk(32'h0, 32'h0, NOP, 1'b0, 1'b1, 1'b1));
        drive_edge(1'b0, 1'b1, 1'b1, 32'h3);
        got = snap(); want = exp_q.pop_front(); n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL misalign_lsb_stalled: got %s want %s", fmt(got), fmt(want));
        end
        test_reset();
    endtask

    task automatic test_wrap();
        exp_q.push_back(mk(32'hFFC, 32'h0, NOP, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h1000, 32'hFFC, 32'd1024, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h1004, 32'h1000, 32'd1, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            drive_edge(1'b0, 1'b0, (k == 0), 32'hFFC);
            got = snap(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %s want %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(mk(32'h100, 32'h0, NOP, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h200, 32'h0, NOP, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h204, 32'h200, 32'd129, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            drive_edge(1'b0, 1'b0, (k < 2), (k == 0) ? 32'h100 : 32'h200);
            got = snap(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %s want %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_reset_priority();
        exp_q.push_back(mk(32'h204, 32'h200, 32'd129, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h4, 32'h0, 32'd1, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            drive_edge((k == 1), (k < 2), (k == 1), 32'h80);
            got = snap(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_priority[%0d]: got %s want %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i + 1);
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_reset_priority();
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
Instruction-fetch front end that sits directly upstream of the instruction memory. Holds the 32-bit program counter and drives the word index into instruction memory. Captures the returned instruction into the IF/ID pipeline register. Handles sequential fetch, branch/jump redirects from execute, stalls, and misaligned-target trapping.

Parameters:
ADDR_W, 10, instruction-memory index width (1024 words, 4 KB)
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSN, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
stall  input  1  hazard stall from decode; freeze PC and IF/ID
redirect  input  1  taken branch / jal / jalr from execute
redirect_target  input  32  byte address of redirect destination (jalr LSB already cleared by execute)
insn_in  input  32  instruction returned by instruction memory (combinational read of pc_out)
pc_out  output  ADDR_W  word index to instruction memory = pc[ADDR_W+1:2]
pc  output  32  current fetch byte address
if_id_pc  output  32  PC of the instruction held in IF/ID
if_id_insn  output  32  instruction held in IF/ID
if_id_valid  output  1  IF/ID holds a real instruction
halted  output  1  fetch stopped by a trap
misalign  output  1  sticky: halt was caused by a misaligned redirect target

Behaviour:
- Reset (rst=1 at posedge): pc=RESET_PC, if_id_pc=0, if_id_insn=NOP_INSN, if_id_valid=0, halted=0, misalign=0, state=RUN. Reset wins over every other input, in any state and mid-stall.
- pc_out is combinational from pc. Instruction memory read is combinational, so insn_in is valid in the same cycle.
- FSM states: RUN, HALT.
- RUN, priority per posedge is redirect > stall > advance:
  - redirect=1 and redirect_target[1:0]==0: pc<=redirect_target; IF/ID flushed (valid=0, insn=NOP_INSN, pc=0). Applies even when stall=1.
  - redirect=1 and redirect_target[1:0]!=0: state<=HALT; halted<=1; misalign<=1; IF/ID flushed; pc holds.
  - stall=1 and redirect=0: pc and all IF/ID outputs hold.
  - Otherwise (advance): pc<=pc+4; if_id_insn<=insn_in; if_id_pc<=pc; if_id_valid<=1.
- HALT: pc held, IF/ID held flushed, halted=1, misalign held. Only rst exits.
- Arithmetic: pc+4 is modulo 2^32. pc_out uses only bits [ADDR_W+1:2], so the index wraps from 1023 to 0 at every 4 KB boundary. Upper PC bits are carried but ignored for addressing.
- Latency:
  - Redirect sampled at edge n: pc_out shows the target index after edge n. The target instruction is in IF/ID with valid=1 after edge n+1, given no stall.
  - Redirect penalty: exactly one bubble cycle.

Decomposition:
- Shared package riscv_pkg holds: NOP_INSN constant, RESET_PC default, fetch-state enum {RUN, HALT}, XLEN=32.
- One natural sub-module, if_id_reg: the pipeline register with load/hold/flush controls. PC/next-PC logic and the FSM stay in pc_fetch.

Test Plan:
- Reset then 4 free-running cycles, memory[i]=i+1 -> pc_out 0,1,2,3,4; if_id_insn 1,2,3,4 with if_id_pc 0,4,8,12; valid=1 from the second edge.
- Stall held 3 cycles at pc=8 -> pc, pc_out=2, and IF/ID unchanged for 3 cycles. Fetch resumes at pc=12 on release.
- Redirect to 0x60 at pc=48 with stall=1 simultaneously -> next cycle pc=0x60, pc_out=24, if_id_valid=0 and insn=0x13. Following cycle if_id_insn=memory[24], if_id_pc=0x60.
- Redirect to 0x62 -> halted=1, misalign=1, valid=0, pc frozen for 10 cycles. rst -> pc=0, halted=0, misalign=0.
- pc=0xFFC advancing -> pc=0x1000, pc_out wraps 1023->0, if_id_pc=0xFFC.
- rst asserted during a stall with redirect=1 -> pc=RESET_PC, valid=0; redirect ignored.
